// File: rtl/robot_cmd_arbiter_if.sv
// Command bus between the IR/UART source decoders and the command arbiter.
`timescale 1ns/1ps
interface robot_cmd_arbiter_if;
  logic [7:0] ir_data;
  logic       ir_vld;
  logic [7:0] uart_data;
  logic       uart_vld;
  logic [7:0] cmd_data;
  logic       cmd_stb;
  logic [1:0] owner;
  logic [7:0] drop_cnt;

  modport master (
    output ir_data, ir_vld, uart_data, uart_vld,
    input  cmd_data, cmd_stb, owner, drop_cnt
  );

  modport slave (
    input  ir_data, ir_vld, uart_data, uart_vld,
    output cmd_data, cmd_stb, owner, drop_cnt
  );
endinterface

// File: rtl/robot_cmd_arbiter.sv
// Two-source ownership arbiter for the 8-bit robot command bus, STOP_CODE on owner timeout.
// Define CMD_ARB_DEDUP_EN to suppress strobes for owner repeats of the current code.
`timescale 1ns/1ps
module robot_cmd_arbiter #(
  parameter int unsigned      CNT_W     = 26,
  parameter logic [CNT_W-1:0] OWN_CYC   = CNT_W'(50_000_000),
  parameter logic [7:0]       STOP_CODE = 8'd13,
  parameter logic [7:0]       IDLE_CODE = 8'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  robot_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_OWN_IR   = 2'b01,
    S_OWN_UART = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RELOAD = OWN_CYC - ONE;

  state_e           state_q;
  logic [7:0]       cmd_data_q;
  logic             cmd_stb_q;
  logic [7:0]       drop_cnt_q;
  logic [CNT_W-1:0] timer_q;

  logic       ir_ok;
  logic       uart_ok;
  logic       own_ok;
  logic       other_ok;
  logic       drop_inc;
  logic [7:0] own_data;

  // A zero code is a void frame: it never accepts, drops or reloads.
  assign ir_ok   = bus.ir_vld   && (bus.ir_data   != 8'd0);
  assign uart_ok = bus.uart_vld && (bus.uart_data != 8'd0);

  always_comb begin
    own_ok   = 1'b0;
    other_ok = 1'b0;
    own_data = bus.ir_data;
    case (state_q)
      S_OWN_IR: begin
        own_ok   = ir_ok;
        other_ok = uart_ok;
        own_data = bus.ir_data;
      end
      S_OWN_UART: begin
        own_ok   = uart_ok;
        other_ok = ir_ok;
        own_data = bus.uart_data;
      end
      default: ;
    endcase
    drop_inc = (state_q == S_IDLE) ? (ir_ok && uart_ok) : other_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_data_q <= IDLE_CODE;
      cmd_stb_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
      timer_q    <= '0;
    end else begin
      cmd_stb_q <= 1'b0;
      if (drop_inc && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (ir_ok) begin
            cmd_data_q <= bus.ir_data;
            cmd_stb_q  <= 1'b1;
            timer_q    <= RELOAD;
            state_q    <= S_OWN_IR;
          end else if (uart_ok) begin
            cmd_data_q <= bus.uart_data;
            cmd_stb_q  <= 1'b1;
            timer_q    <= RELOAD;
            state_q    <= S_OWN_UART;
          end
        end
        default: begin
          // Owner traffic is checked before expiry so a command on the last cycle keeps ownership.
          if (own_ok) begin
            timer_q <= RELOAD;
`ifdef CMD_ARB_DEDUP_EN
            if (own_data != cmd_data_q) begin
              cmd_data_q <= own_data;
              cmd_stb_q  <= 1'b1;
            end
`else
            cmd_data_q <= own_data;
            cmd_stb_q  <= 1'b1;
`endif
          end else if (timer_q == '0) begin
            cmd_data_q <= STOP_CODE;
            cmd_stb_q  <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            timer_q <= timer_q - ONE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_data = cmd_data_q;
  assign bus.cmd_stb  = cmd_stb_q;
  assign bus.owner    = state_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
